scalar_seq_ctrl: RTL and testbench

SCALAR_SEQ_CTRL -- requirements
Module: scalar_seq_ctrl

---
 rtl/scalar_seq_ctrl_pkg.sv | 24 ++
 rtl/scalar_seq_ctrl_elem_mult.sv | 21 ++
 rtl/scalar_seq_ctrl.sv | 97 +++++++++
 tb/tb_scalar_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scalar_seq_ctrl_pkg.sv
// Shared coprocessor definitions: FSM encodings, matrix capacity and the
// size-code to element-count mapping.
package scalar_seq_ctrl_pkg;

    localparam int MAX_ELEMS = 25;
    localparam int IDX_W     = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [IDX_W-1:0] size_to_n(input logic [1:0] size);
        logic [IDX_W-1:0] n;
        case (size)
            2'b00:   n = 5'd4;
            2'b01:   n = 5'd9;
            2'b10:   n = 5'd16;
            2'b11:   n = 5'd25;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/scalar_seq_ctrl_elem_mult.sv
// Signed ELEM_W x ELEM_W multiplier returning the truncated product and a
// flag that is set when the full product does not fit in ELEM_W bits.
module elem_mult #(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] prod_lo,
    output logic              ovf
);

    logic signed [2*ELEM_W-1:0] prod_s;

    // Full-width signed product, truncation and overflow detection.
    always_comb begin
        prod_s  = $signed(a) * $signed(b);
        prod_lo = prod_s[ELEM_W-1:0];
        ovf     = (prod_s[2*ELEM_W-1:ELEM_W] != {ELEM_W{prod_s[ELEM_W-1]}});
    end

endmodule

// File: rtl/scalar_seq_ctrl.sv
// Sequential matrix-by-scalar multiplier: one element per cycle, results
// held with a valid/ready handshake until the consumer takes them.
module scalar_seq_ctrl #(
    parameter int ELEM_W    = 8,
    parameter int MAX_ELEMS = scalar_seq_ctrl_pkg::MAX_ELEMS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [MAX_ELEMS*ELEM_W-1:0] cmd_matrix,
    input  logic [ELEM_W-1:0]           cmd_scalar,
    input  logic [1:0]                  cmd_size,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [MAX_ELEMS*ELEM_W-1:0] res_matrix,
    output logic                        res_overflow,
    output logic                        busy
);

    import scalar_seq_ctrl_pkg::*;

    logic [1:0]                  state_r;
    logic [IDX_W-1:0]            index_r;
    logic [IDX_W-1:0]            n_r;
    logic [MAX_ELEMS*ELEM_W-1:0] matrix_r;
    logic [ELEM_W-1:0]           scalar_r;
    logic [MAX_ELEMS*ELEM_W-1:0] res_matrix_r;
    logic                        res_overflow_r;
    logic [ELEM_W-1:0]           elem_s;
    logic [ELEM_W-1:0]           prod_s;
    logic                        ovf_s;

    assign elem_s = matrix_r[index_r*ELEM_W +: ELEM_W];

    elem_mult #(.ELEM_W(ELEM_W)) u_elem_mult (
        .a       (elem_s),
        .b       (scalar_r),
        .prod_lo (prod_s),
        .ovf     (ovf_s)
    );

    // Control FSM, command capture and per-element result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            index_r        <= 5'd0;
            n_r            <= 5'd0;
            matrix_r       <= '0;
            scalar_r       <= '0;
            res_matrix_r   <= '0;
            res_overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        matrix_r       <= cmd_matrix;
                        scalar_r       <= cmd_scalar;
                        n_r            <= size_to_n(cmd_size);
                        index_r        <= 5'd0;
                        res_matrix_r   <= '0;
                        res_overflow_r <= 1'b0;
                        state_r        <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_matrix_r[index_r*ELEM_W +: ELEM_W] <= prod_s;
                    res_overflow_r <= res_overflow_r | ovf_s;
                    if (index_r == n_r - 5'd1) begin
                        state_r <= ST_DONE;
                    end else begin
                        index_r <= index_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state_r == ST_IDLE);
    assign res_valid    = (state_r == ST_DONE);
    assign busy         = (state_r != ST_IDLE);
    assign res_matrix   = res_matrix_r;
    assign res_overflow = res_overflow_r;

endmodule

// File: tb/tb_scalar_seq_ctrl.sv
// Directed bench for scalar_seq_ctrl with hand-computed expected results.
module tb_scalar_seq_ctrl;

    localparam int W  = 8;
    localparam int ME = 25;
    localparam int MW = ME * W;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [MW-1:0] cmd_matrix;
    logic [W-1:0]  cmd_scalar;
    logic [1:0]    cmd_size;
    logic          res_valid;
    logic          res_ready;
    logic [MW-1:0] res_matrix;
    logic          res_overflow;
    logic          busy;

    int checks;
    int errors;

    logic [7:0]    m_a [ME];
    logic [7:0]    e_a [ME];
    logic [MW-1:0] exp_m;
    logic [MW-1:0] held_m;
    int            lat;

    scalar_seq_ctrl #(.ELEM_W(W), .MAX_ELEMS(ME)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_matrix   (cmd_matrix),
        .cmd_scalar   (cmd_scalar),
        .cmd_size     (cmd_size),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_matrix   (res_matrix),
        .res_overflow (res_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] pack(input logic [7:0] a [ME]);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < ME; i++) v[i*W +: W] = a[i];
        return v;
    endfunction

    task automatic send(input logic [1:0] sz, input logic [7:0] sc);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_size   = sz;
        cmd_scalar = sc;
        cmd_matrix = pack(m_a);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_matrix = ~cmd_matrix;
        cmd_scalar = 8'h7F;
        cmd_size   = ~sz;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!res_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        check("ready_in_done_cycle", {199'd0, cmd_ready}, {199'd0, 1'b0});
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("idle_cmd_ready", {199'd0, cmd_ready}, {199'd0, 1'b1});
        check("idle_res_valid", {199'd0, res_valid}, {199'd0, 1'b0});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_matrix = '0; cmd_scalar = 8'h00;
        cmd_size = 2'b00; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {199'd0, cmd_ready}, {199'd0, 1'b1});
        check("rst_outputs", {res_matrix[197:0], res_valid, res_overflow}, '0);
        check("rst_busy", {199'd0, busy}, {199'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // 2x2 [1,2,3,4] * 3, unused slots filled with junk
        for (int i = 0; i < ME; i++) begin m_a[i] = 8'h55; e_a[i] = 8'h00; end
        m_a[0] = 8'd1; m_a[1] = 8'd2; m_a[2] = 8'd3; m_a[3] = 8'd4;
        e_a[0] = 8'd3; e_a[1] = 8'd6; e_a[2] = 8'd9; e_a[3] = 8'd12;
        send(2'b00, 8'd3);
        check("t1_busy", {199'd0, busy}, {199'd0, 1'b1});
        wait_done(lat);
        check("t1_latency", MW'(lat), MW'(4));
        check("t1_matrix", res_matrix, pack(e_a));
        check("t1_ovf", {199'd0, res_overflow}, {199'd0, 1'b0});
        release_res();
        check("t1_hold_after", res_matrix, pack(e_a));

        // 5x5 all 16 * 8 = 128 -> 0x80 with overflow
        for (int i = 0; i < ME; i++) begin m_a[i] = 8'd16; e_a[i] = 8'h80; end
        send(2'b11, 8'd8);
        wait_done(lat);
        check("t2_latency", MW'(lat), MW'(25));
        check("t2_matrix", res_matrix, pack(e_a));
        check("t2_ovf", {199'd0, res_overflow}, {199'd0, 1'b1});
        release_res();

        // [-1,0,1,2] * -128 -> [0x80,0x00,0x80,0x00], overflow from +128 and -256
        for (int i = 0; i < ME; i++) begin m_a[i] = 8'h00; e_a[i] = 8'h00; end
        m_a[0] = 8'hFF; m_a[1] = 8'h00; m_a[2] = 8'h01; m_a[3] = 8'h02;
        e_a[0] = 8'h80; e_a[2] = 8'h80;
        send(2'b00, 8'h80);
        wait_done(lat);
        check("t3_matrix", res_matrix, pack(e_a));
        check("t3_ovf", {199'd0, res_overflow}, {199'd0, 1'b1});
        release_res();

        // 3x3 with slots 9..24 preloaded 0x7F, scalar 1
        for (int i = 0; i < ME; i++) begin
            m_a[i] = (i < 9) ? 8'(i + 1) : 8'h7F;
            e_a[i] = (i < 9) ? 8'(i + 1) : 8'h00;
        end
        send(2'b01, 8'd1);
        wait_done(lat);
        check("t4_latency", MW'(lat), MW'(9));
        check("t4_matrix", res_matrix, pack(e_a));
        check("t4_ovf", {199'd0, res_overflow}, {199'd0, 1'b0});

        // hold in DONE for 10 cycles with a competing command offered
        held_m = res_matrix;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            check("hold_valid", {199'd0, res_valid}, {199'd0, 1'b1});
            check("hold_cmd_ready", {199'd0, cmd_ready}, {199'd0, 1'b0});
            check("hold_matrix", res_matrix, held_m);
            check("hold_ovf", {199'd0, res_overflow}, {199'd0, 1'b0});
        end
        cmd_valid = 1'b0;
        release_res();
        check("t4_after_release", res_matrix, pack(e_a));

        // reset 5 cycles into a 4x4 run
        for (int i = 0; i < ME; i++) m_a[i] = 8'h11;
        send(2'b10, 8'd2);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {res_matrix[197:0], res_valid, res_overflow}, '0);
        check("abort_busy", {199'd0, busy}, {199'd0, 1'b0});
        check("abort_cmd_ready", {199'd0, cmd_ready}, {199'd0, 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4 elems i * 9, element 15 (135) overflows
        for (int i = 0; i < ME; i++) begin
            m_a[i] = (i < 16) ? 8'(i) : 8'h33;
            e_a[i] = (i < 16) ? 8'(i * 9) : 8'h00;
        end
        send(2'b10, 8'd9);
        wait_done(lat);
        check("t6_latency", MW'(lat), MW'(16));
        check("t6_matrix", res_matrix, pack(e_a));
        check("t6_ovf", {199'd0, res_overflow}, {199'd0, 1'b1});
        release_res();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
